// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types for the two-source Ethernet TX arbiter: stream beat, FSM state
// and source identifiers.
package eth_tx_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } st_beat_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_ARP = 2'd1,
    GNT_UDP = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_ARP = 1'b0,
    SRC_UDP = 1'b1
  } src_t;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Avalon-ST packet stream (data/valid/sop/eop/empty with ready backpressure).
interface eth_tx_arbiter_if;
  import eth_tx_arbiter_pkg::*;

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               ready;

  modport master (output data, valid, sop, eop, empty, input  ready);
  modport slave  (input  data, valid, sop, eop, empty, output ready);

endinterface

// File: rtl/eth_st_reg_slice.sv
// Single-entry output register: captures a beat when in_beat.valid is high and
// holds it until the sink takes it.
module eth_st_reg_slice
  import eth_tx_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  st_beat_t in_beat,
  input  logic     out_ready,
  output st_beat_t out_beat
);

  // NOTE: data fields are reset as well as valid so the MAC never sees stale
  // X or a leftover sop/eop after reset; cost is negligible for one register.
  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_beat <= '0;
    end else if (in_beat.valid) begin
      out_beat <= in_beat;
    end else if (out_ready) begin
      out_beat.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin merge of the ARP-reply and UDP-TX streams onto one
// MAC-side stream, with per-source packet counters and an orphan-beat counter.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  eth_tx_arbiter_if.slave     arp,
  eth_tx_arbiter_if.slave     udp,
  eth_tx_arbiter_if.master    avso,
  output logic [CNT_W-1:0]    arp_pkt_cnt,
  output logic [CNT_W-1:0]    udp_pkt_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                busy
);

  arb_state_t state, state_nxt;
  src_t       last_grant, last_grant_nxt;
  st_beat_t   sel_beat, out_beat;
  logic       arp_rdy, udp_rdy;
  logic       arp_done, udp_done;
  logic       slot_free;
  logic [1:0] drop_inc;

  assign slot_free = ~out_beat.valid | avso.ready;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    arp_rdy        = 1'b0;
    udp_rdy        = 1'b0;
    arp_done       = 1'b0;
    udp_done       = 1'b0;
    drop_inc       = 2'd0;
    sel_beat       = '0;

    case (state)
      IDLE: begin
        // Mid-packet beats with no owner are swallowed; sop beats wait for grant.
        arp_rdy  = arp.valid & ~arp.sop;
        udp_rdy  = udp.valid & ~udp.sop;
        drop_inc = {1'b0, arp_rdy} + {1'b0, udp_rdy};
        if (arp.valid && arp.sop && udp.valid && udp.sop) begin
          state_nxt = (last_grant == SRC_UDP) ? GNT_ARP : GNT_UDP;
        end else if (arp.valid && arp.sop) begin
          state_nxt = GNT_ARP;
        end else if (udp.valid && udp.sop) begin
          state_nxt = GNT_UDP;
        end
      end

      GNT_ARP: begin
        arp_rdy = slot_free;
        if (arp.valid && slot_free) begin
          sel_beat = '{data: arp.data, valid: 1'b1, sop: arp.sop,
                       eop: arp.eop, empty: arp.empty};
          if (arp.eop) begin
            state_nxt      = IDLE;
            last_grant_nxt = SRC_ARP;
            arp_done       = 1'b1;
          end
        end
      end

      GNT_UDP: begin
        udp_rdy = slot_free;
        if (udp.valid && slot_free) begin
          sel_beat = '{data: udp.data, valid: 1'b1, sop: udp.sop,
                       eop: udp.eop, empty: udp.empty};
          if (udp.eop) begin
            state_nxt      = IDLE;
            last_grant_nxt = SRC_UDP;
            udp_done       = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= SRC_UDP;
      arp_pkt_cnt <= '0;
      udp_pkt_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (arp_done) arp_pkt_cnt <= arp_pkt_cnt + CNT_W'(1);
      if (udp_done) udp_pkt_cnt <= udp_pkt_cnt + CNT_W'(1);
      drop_cnt <= drop_cnt + CNT_W'(drop_inc);
    end
  end

  eth_st_reg_slice u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .in_beat   (sel_beat),
    .out_ready (avso.ready),
    .out_beat  (out_beat)
  );

  // Readies are held low for the whole reset window, not just after it.
  assign arp.ready  = arp_rdy & ~reset;
  assign udp.ready  = udp_rdy & ~reset;

  assign avso.data  = out_beat.data;
  assign avso.valid = out_beat.valid;
  assign avso.sop   = out_beat.sop;
  assign avso.eop   = out_beat.eop;
  assign avso.empty = out_beat.empty;

  assign busy = (state != IDLE);

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of per-source statistics counters.
REQ-002 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports arp_data/arp_valid/arp_sop/arp_eop/arp_empty  in  32/1/1/1/2  source 0 (ARP reply) Avalon-ST, with arp_ready  out  1.
REQ-005 SHALL have ports udp_data/udp_valid/udp_sop/udp_eop/udp_empty  in  32/1/1/1/2  source 1 (UDP TX) Avalon-ST, with udp_ready  out  1.
REQ-006 SHALL have ports avso_data/avso_valid/avso_sop/avso_eop/avso_empty  out  32/1/1/1/2  merged MAC-side stream, with avso_ready  in  1.
REQ-007 SHALL have ports arp_pkt_cnt, udp_pkt_cnt, drop_cnt  out  CNT_W  packets forwarded per source, orphan beats discarded.
REQ-008 SHALL have port busy  out  1  high while a packet is granted.

Function
REQ-009 A beat SHALL transfer on any interface only when valid and ready are both high at a rising edge.
REQ-010 FSM states: IDLE, GNT_ARP, GNT_UDP; reset state IDLE.
REQ-011 IDLE: if exactly one source presents valid&sop, grant it (next state GNT_ARP/GNT_UDP); if both, grant the source not granted last (last_grant resets to UDP, so ARP wins first tie).
REQ-012 IDLE: arp_ready/udp_ready SHALL be high only for a source presenting valid&!sop; such beats are discarded and drop_cnt increments by 1 per beat (both sources same cycle: +2).
REQ-013 IDLE: sop beats SHALL NOT be consumed; arbitration costs one bubble cycle.
REQ-014 GNT_x: granted source ready = (!avso_valid | avso_ready); non-granted ready = 0.
REQ-015 Output stage SHALL be one register: loads accepted beat (data, sop, eop, empty) and sets avso_valid; clears avso_valid when avso_ready and no new beat accepted.
REQ-016 Latency: sop valid in IDLE at edge N arbitrates; beat accepted at edge N+1 (ready permitting); avso_valid high after edge N+1; full throughput 1 beat/cycle thereafter while avso_ready high.
REQ-017 Accepting the granted eop beat SHALL return FSM to IDLE next cycle, update last_grant, and increment that source's pkt_cnt.
REQ-018 A granted sop beat arriving mid-packet (no eop seen) SHALL be forwarded unchanged; no repair.
REQ-019 Single-beat packet (sop&eop) SHALL grant, forward and return to IDLE as REQ-017.
REQ-020 Counters SHALL wrap modulo 2^CNT_W.
REQ-021 avso_data/avso_sop/avso_eop/avso_empty SHALL hold stable while avso_valid & !avso_ready.
REQ-022 busy = (state != IDLE).

Reset
REQ-023 On reset: state IDLE, last_grant UDP, avso_valid 0, avso_sop 0, avso_eop 0, avso_data 0, avso_empty 0, all counters 0, both readies 0.
REQ-024 Reset mid-packet SHALL truncate the packet without emitting eop; no recovery beat.

Structure
REQ-025 Shared package SHALL hold the stream struct (data 32, valid, sop, eop, empty 2) and the state enum.
REQ-026 Single module; output register MAY be sub-module eth_st_reg_slice.

Verification
REQ-027 ARP 11-beat packet alone, avso_ready=1 -> 11 beats out, sop on 1st, eop on 11th, arp_pkt_cnt=1, first avso_valid 2 edges after arp_valid.
REQ-028 ARP and UDP sop same cycle after reset -> ARP packet out first, then UDP after 1 bubble; counts 1/1.
REQ-029 Both sources continuously backlogged, 4 packets each -> strict alternation ARP,UDP,ARP,...
REQ-030 avso_ready toggled 1010 during UDP packet -> no beat lost/duplicated, data stable while stalled.
REQ-031 UDP valid beat with sop=0 in IDLE (3 beats) -> consumed, nothing output, drop_cnt=3.
REQ-032 reset asserted at beat 5 of 11 -> avso_valid 0 immediately, counters 0, next packet forwarded normally.
